// File: rtl/pipelined_barrel_rotator.sv
// Pipelined rotate / logical-shift unit: stage k conditionally shifts by 2^k.
// Valid/ready on both sides; every stage can collapse bubbles independently.
module pipelined_barrel_rotator #(
   parameter  int N      = 8,
   localparam int SW     = $clog2(N),
   localparam int STAGES = SW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          up_valid,
   output logic          up_ready,
   input  logic [N-1:0]  up_data,
   input  logic [SW-1:0] up_shamt,
   input  logic          up_dir,
   input  logic          up_rot,
   output logic          down_valid,
   input  logic          down_ready,
   output logic [N-1:0]  down_data
);

   if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
      $error("pipelined_barrel_rotator: N must be a power of two and at least 4");
   end

   localparam logic [STAGES-1:0] ALL_VLD = '1;

   logic [STAGES-1:0] vld_q, vld_d;
   logic [STAGES-1:0] dir_q, dir_d;
   logic [STAGES-1:0] rot_q, rot_d;
   logic [N-1:0]      data_q  [STAGES];
   logic [N-1:0]      data_d  [STAGES];
   logic [SW-1:0]     shamt_q [STAGES];
   logic [SW-1:0]     shamt_d [STAGES];
   logic [STAGES-1:0] rdy;

   function automatic logic [N-1:0] shift_stage(input logic [N-1:0] x, input int d,
                                                input logic en, input logic dir,
                                                input logic rot);
      logic [N-1:0] l;
      logic [N-1:0] r;
      l = x << d;
      r = x >> d;
      if (rot) begin
         l = l | (x >> (N - d));
         r = r | (x << (N - d));
      end
      if (!en) return x;
      return dir ? r : l;
   endfunction

   // ready_k is true when down_ready is high or any stage from k onward is empty;
   // written in closed form so the chain has no combinational self-loop.
   always_comb begin
      rdy = '0;
      for (int k = 0; k < STAGES; k++) begin
         rdy[k] = down_ready | ((vld_q >> k) != (ALL_VLD >> k));
      end
   end

   always_comb begin
      logic          src_vld;
      logic [N-1:0]  src_data;
      logic [SW-1:0] src_shamt;
      logic          src_dir;
      logic          src_rot;
      int            prv;
      vld_d     = vld_q;
      dir_d     = dir_q;
      rot_d     = rot_q;
      data_d    = data_q;
      shamt_d   = shamt_q;
      src_vld   = 1'b0;
      src_data  = '0;
      src_shamt = '0;
      src_dir   = 1'b0;
      src_rot   = 1'b0;
      prv       = 0;
      for (int k = 0; k < STAGES; k++) begin
         prv       = (k == 0) ? 0 : k - 1;
         src_vld   = (k == 0) ? up_valid : vld_q[prv];
         src_data  = (k == 0) ? up_data  : data_q[prv];
         src_shamt = (k == 0) ? up_shamt : shamt_q[prv];
         src_dir   = (k == 0) ? up_dir   : dir_q[prv];
         src_rot   = (k == 0) ? up_rot   : rot_q[prv];
         if (rdy[k]) begin
            vld_d[k]   = src_vld;
            data_d[k]  = shift_stage(src_data, 1 << k, src_shamt[k], src_dir, src_rot);
            shamt_d[k] = src_shamt;
            dir_d[k]   = src_dir;
            rot_d[k]   = src_rot;
         end
      end
   end

   // Stage registers: all stages advance together, each gated by its own ready.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= '0;
         dir_q <= '0;
         rot_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k]  <= '0;
            shamt_q[k] <= '0;
         end
      end else begin
         vld_q   <= vld_d;
         dir_q   <= dir_d;
         rot_q   <= rot_d;
         data_q  <= data_d;
         shamt_q <= shamt_d;
      end
   end

   assign up_ready   = rdy[0];
   assign down_valid = vld_q[STAGES-1];
   assign down_data  = data_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_barrel_rotator.sv
// Scoreboard bench for pipelined_barrel_rotator at N = 8 and N = 32.
// Expected words are queued on acceptance; monitors pop them on each output transfer.
module tb_pipelined_barrel_rotator;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       v8 = 1'b0, r8, dir8 = 1'b0, rot8 = 1'b0, dv8, dr8 = 1'b1;
   logic [7:0] d8 = '0, dd8;
   logic [2:0] s8 = '0;

   logic        v32 = 1'b0, r32, dir32 = 1'b0, rot32 = 1'b0, dv32, dr32 = 1'b1;
   logic [31:0] d32 = '0, dd32;
   logic [4:0]  s32 = '0;

   pipelined_barrel_rotator #(.N(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .up_valid(v8), .up_ready(r8), .up_data(d8), .up_shamt(s8), .up_dir(dir8), .up_rot(rot8),
      .down_valid(dv8), .down_ready(dr8), .down_data(dd8));

   pipelined_barrel_rotator #(.N(32)) dut32 (
      .clk(clk), .rst_n(rst_n),
      .up_valid(v32), .up_ready(r32), .up_data(d32), .up_shamt(s32), .up_dir(dir32), .up_rot(rot32),
      .down_valid(dv32), .down_ready(dr32), .down_data(dd32));

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0]  exp8[$];
   logic [31:0] exp32[$];
   int outcyc8[$];
   int outcnt8 = 0, outcnt32 = 0, stall8 = 0, acc8 = 0, acc32 = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   task automatic fail_now(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   // Reference: result bit i comes from source bit i-d (left) or i+d (right),
   // wrapping modulo n for rotate and reading zero outside the word for shifts.
   function automatic logic [31:0] ref_model(input logic [31:0] x, input int n, input int d,
                                             input bit dir, input bit rot);
      logic [31:0] r;
      int src;
      r = '0;
      for (int i = 0; i < n; i++) begin
         src = dir ? i + d : i - d;
         if (rot) src = (src + n) % n;
         if (src >= 0 && src < n) r[i] = x[src];
      end
      return r;
   endfunction

   // ---------------- monitors ----------------
   logic hold8 = 1'b0;
   logic [7:0] held8 = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         hold8 = 1'b0;
      end else begin
         if (hold8) begin
            chk("stall_valid8", {31'b0, dv8}, 32'd1);
            chk("stall_data8", {24'b0, dd8}, {24'b0, held8});
         end
         if (dv8 && dr8) begin
            outcnt8++;
            outcyc8.push_back(cyc);
            if (exp8.size() == 0) fail_now("spurious_out8");
            else chk("out8", {24'b0, dd8}, {24'b0, exp8.pop_front()});
         end
         hold8 = dv8 && !dr8;
         held8 = dd8;
      end
   end

   always @(negedge clk) begin
      if (rst_n && dv32 && dr32) begin
         outcnt32++;
         if (exp32.size() == 0) fail_now("spurious_out32");
         else chk("out32", dd32, exp32.pop_front());
      end
   end

   // ---------------- drivers ----------------
   task automatic send8(input logic [7:0] d, input logic [2:0] s, input logic dir,
                        input logic rot, input logic [7:0] expv);
      bit ok = 0;
      v8 = 1'b1; d8 = d; s8 = s; dir8 = dir; rot8 = rot;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         if (r8) begin
            exp8.push_back(expv);
            acc8 = cyc;
            ok = 1;
         end else begin
            stall8++;
         end
         @(posedge clk); #1;
      end
      v8 = 1'b0; d8 = 'x; s8 = 'x; dir8 = 'x; rot8 = 'x;
      if (!ok) fail_now("accept_timeout8");
   endtask

   task automatic send8_rand();
      logic [7:0] d;
      logic [2:0] s;
      logic dir, rot;
      d = 8'($urandom); s = 3'($urandom); dir = 1'($urandom); rot = 1'($urandom);
      send8(d, s, dir, rot, ref_model({24'b0, d}, 8, int'(s), dir, rot) & 32'hFF);
   endtask

   task automatic send32(input logic [31:0] d, input logic [4:0] s, input logic dir, input logic rot);
      bit ok = 0;
      v32 = 1'b1; d32 = d; s32 = s; dir32 = dir; rot32 = rot;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         if (r32) begin
            exp32.push_back(ref_model(d, 32, int'(s), dir, rot));
            acc32 = cyc;
            ok = 1;
         end
         @(posedge clk); #1;
      end
      v32 = 1'b0; d32 = 'x; s32 = 'x; dir32 = 'x; rot32 = 'x;
      if (!ok) fail_now("accept_timeout32");
   endtask

   task automatic wait_valid8(output int c);
      c = -1;
      for (int t = 0; t < 20 && c < 0; t++) begin
         @(negedge clk);
         if (dv8) c = cyc;
      end
      if (c < 0) fail_now("valid_timeout8");
      @(posedge clk); #1;
   endtask

   task automatic drain(input string nm);
      int t = 0;
      while ((exp8.size() != 0 || exp32.size() != 0) && t < 400) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 400) fail_now(nm);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int c, base, acc, idx;
      logic [7:0] words [5];

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_down_valid8", {31'b0, dv8}, 32'd0);
      chk("rst_down_data8", {24'b0, dd8}, 32'd0);
      chk("rst_down_valid32", {31'b0, dv32}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_up_ready8", {31'b0, r8}, 32'd1);
      chk("rst_up_ready32", {31'b0, r32}, 32'd1);
      @(posedge clk); #1;

      // directed rotate/shift values, with latency on the first word
      send8(8'b10110101, 3'd3, 1'b0, 1'b1, 8'b10101101);
      wait_valid8(c);
      chk("latency8", 32'(c - acc8), 32'd3);
      send8(8'b10110101, 3'd3, 1'b1, 1'b1, 8'b10110110);
      send8(8'b10110101, 3'd3, 1'b0, 1'b0, 8'b10101000);
      send8(8'b10110101, 3'd3, 1'b1, 1'b0, 8'b00010110);
      for (int m = 0; m < 4; m++) send8(8'b10110101, 3'd0, m[0], m[1], 8'b10110101);
      send8(8'b00000001, 3'd7, 1'b1, 1'b1, 8'b00000010);
      drain("drain_directed");

      // streaming: 20 back-to-back words, no stalls allowed
      outcyc8.delete();
      stall8 = 0;
      for (int i = 0; i < 20; i++) send8_rand();
      drain("drain_stream");
      chk("stream_up_ready_stalls", 32'(stall8), 32'd0);
      chk("stream_out_count", 32'(outcyc8.size()), 32'd20);
      if (outcyc8.size() == 20) chk("stream_consecutive", 32'(outcyc8[19] - outcyc8[0]), 32'd19);

      // backpressure: 5 words offered against a stalled consumer
      dr8 = 1'b0;
      acc = 0;
      idx = 0;
      for (int i = 0; i < 5; i++) words[i] = 8'($urandom);
      for (int t = 0; t < 5; t++) begin
         v8 = 1'b1; d8 = words[idx]; s8 = 3'd5; dir8 = 1'b1; rot8 = 1'b1;
         @(negedge clk);
         if (r8) begin
            exp8.push_back(8'(ref_model({24'b0, words[idx]}, 8, 5, 1'b1, 1'b1)));
            acc++;
            idx++;
         end
         @(posedge clk); #1;
      end
      v8 = 1'b0;
      @(negedge clk);
      chk("bp_accepted", 32'(acc), 32'd3);
      chk("bp_up_ready_low", {31'b0, r8}, 32'd0);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      dr8 = 1'b1;
      @(negedge clk);
      chk("bp_release_up_ready", {31'b0, r8}, 32'd1);
      @(posedge clk); #1;
      drain("drain_bp");

      // random toggling of down_ready with random input gaps
      base = outcnt8;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
               send8_rand();
            end
         end
         begin
            for (int t = 0; t < 120; t++) begin
               @(posedge clk); #1;
               dr8 = 1'($urandom);
            end
         end
      join
      dr8 = 1'b1;
      drain("drain_toggle");
      chk("toggle_out_count", 32'(outcnt8 - base), 32'd40);

      // reset with three words in flight
      dr8 = 1'b0;
      for (int i = 0; i < 3; i++) send8_rand();
      rst_n = 1'b0;
      exp8.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_down_valid", {31'b0, dv8}, 32'd0);
      chk("midrst_down_data", {24'b0, dd8}, 32'd0);
      chk("midrst_up_ready", {31'b0, r8}, 32'd1);
      @(posedge clk); #1;
      dr8 = 1'b1;
      base = outcnt8;
      send8(8'h3C, 3'd2, 1'b0, 1'b1, 8'hF0);
      wait_valid8(c);
      chk("midrst_latency", 32'(c - acc8), 32'd3);
      repeat (6) @(posedge clk);
      #1;
      chk("midrst_single_out", 32'(outcnt8 - base), 32'd1);

      // N = 32: latency then 1000 random words with light backpressure
      send32(32'h8000_0001, 5'd31, 1'b0, 1'b1);
      c = -1;
      for (int t = 0; t < 20 && c < 0; t++) begin
         @(negedge clk);
         if (dv32) c = cyc;
      end
      if (c < 0) fail_now("valid_timeout32");
      else chk("latency32", 32'(c - acc32), 32'd5);
      @(posedge clk); #1;
      base = outcnt32;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               if (i < 4) send32($urandom, (i < 2) ? 5'd0 : 5'd31, i[0], i[1]);
               else send32($urandom, 5'($urandom), 1'($urandom), 1'($urandom));
            end
         end
         begin
            for (int t = 0; t < 1100; t++) begin
               @(posedge clk); #1;
               dr32 = ($urandom_range(0, 3) != 0);
            end
         end
      join
      dr32 = 1'b1;
      drain("drain32");
      chk("n32_out_count", 32'(outcnt32 - base), 32'd1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
